bram_arbiter: RTL

Two-master arbiter and sequencer for one port of the byte-addressable 32-bit BRAM (`addr_width` words, 4 byte lanes, 1-cycle read latency). Masters M0 and M1 issue single-word read or byte-masked write commands with a req/ready handshake. The block grants round-robin, supports a lock for atomic multi-access sequences with a starvation limit, and returns read data with a per-master valid pulse. It sits between the CPU/DMA masters and the BRAM port, which it drives directly.

---
 rtl/bram_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter
// Two-master round-robin arbiter and sequencer for one port of a 32-bit,
// 4-lane, byte-addressable BRAM with 1-cycle read latency. Supports an
// exclusive lock for atomic multi-access sequences, bounded by lock_max
// consecutive transfers while the other master waits (0 = unbounded).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mX_req/lock/addr/we/wdata  master X command (we == 0000 means read)
//   mX_ready                command accepted this cycle (combinational)
//   mX_rvalid/rdata         read response, one cycle after acceptance
//   bram_clken/addr/we/wdata  BRAM port drive
//   bram_rdata              BRAM read data (valid 1 cycle after access)
module bram_arbiter #(
  parameter int unsigned addr_width = 12,
  parameter int unsigned lock_max   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic [addr_width-1:0] m0_addr,
  input  logic [3:0]            m0_we,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_ready,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic [addr_width-1:0] m1_addr,
  input  logic [3:0]            m1_we,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_ready,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic                  bram_clken,
  output logic [addr_width-1:0] bram_addr,
  output logic [3:0]            bram_we,
  output logic [31:0]           bram_wdata,
  input  logic [31:0]           bram_rdata
);

  localparam int unsigned   LCW   = (lock_max == 0) ? 1 : $clog2(lock_max + 1);
  localparam logic [LCW-1:0] LCMAX = LCW'(lock_max);

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_last;
  logic           w_last_nxt;
  logic [LCW-1:0] r_lcnt;
  logic [LCW-1:0] w_lcnt_nxt;
  logic [LCW-1:0] w_lcnt_inc;
  logic           w_lim_hit;
  logic           w_gnt0;
  logic           w_gnt1;
  logic           r_m0_rvalid;
  logic           r_m1_rvalid;

  // State register: lock state, last-granted index, lock counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FREE;
      r_last  <= 1'b1;
      r_lcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_lcnt  <= w_lcnt_nxt;
    end
  end

  assign w_lcnt_inc = r_lcnt + 1'b1;
  // Limit is judged on the count this accepted transfer would produce, so
  // the lock drops right after the lock_max-th contended transfer.
  assign w_lim_hit  = (lock_max != 0) && (w_lcnt_inc == LCMAX);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_lcnt_nxt  = r_lcnt;

    if (w_gnt0) begin
      w_last_nxt = 1'b0;
    end else if (w_gnt1) begin
      w_last_nxt = 1'b1;
    end

    case (r_state)
      S_FREE: begin
        w_lcnt_nxt = '0;
        if (w_gnt0 && m0_lock) begin
          w_state_nxt = S_LOCK0;
        end else if (w_gnt1 && m1_lock) begin
          w_state_nxt = S_LOCK1;
        end
      end
      S_LOCK0: begin
        if (!m1_req) begin
          w_lcnt_nxt = '0;
        end else if (w_gnt0) begin
          w_lcnt_nxt = w_lcnt_inc;
        end
        if (w_gnt0 && !m0_lock) begin
          w_state_nxt = S_FREE;
        end else if (!m0_req && !m0_lock) begin
          w_state_nxt = S_FREE;
        end else if (w_gnt0 && m1_req && w_lim_hit) begin
          w_state_nxt = S_FREE;
        end
        if (w_state_nxt == S_FREE) begin
          w_lcnt_nxt = '0;
        end
      end
      S_LOCK1: begin
        if (!m0_req) begin
          w_lcnt_nxt = '0;
        end else if (w_gnt1) begin
          w_lcnt_nxt = w_lcnt_inc;
        end
        if (w_gnt1 && !m1_lock) begin
          w_state_nxt = S_FREE;
        end else if (!m1_req && !m1_lock) begin
          w_state_nxt = S_FREE;
        end else if (w_gnt1 && m0_req && w_lim_hit) begin
          w_state_nxt = S_FREE;
        end
        if (w_state_nxt == S_FREE) begin
          w_lcnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_FREE;
        w_lcnt_nxt  = '0;
      end
    endcase
  end

  // Output logic: grant decision and BRAM port drive.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_LOCK0: w_gnt0 = m0_req;
        S_LOCK1: w_gnt1 = m1_req;
        default: begin
          // r_last == 1 means M1 was granted last, so M0 wins contention.
          w_gnt0 = m0_req && (!m1_req || r_last);
          w_gnt1 = m1_req && (!m0_req || !r_last);
        end
      endcase
    end
  end

  always_comb begin
    bram_clken = w_gnt0 | w_gnt1;
    bram_addr  = '0;
    bram_we    = '0;
    bram_wdata = '0;
    if (w_gnt1) begin
      bram_addr  = m1_addr;
      bram_we    = m1_we;
      bram_wdata = m1_wdata;
    end else if (w_gnt0) begin
      bram_addr  = m0_addr;
      bram_we    = m0_we;
      bram_wdata = m0_wdata;
    end
  end

  // Read response: one-cycle pulse after an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_m0_rvalid <= w_gnt0 && (m0_we == 4'b0000);
      r_m1_rvalid <= w_gnt1 && (m1_we == 4'b0000);
    end
  end

  assign m0_ready  = w_gnt0;
  assign m1_ready  = w_gnt1;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = bram_rdata;
  assign m1_rdata  = bram_rdata;

endmodule
